// File: rtl/usm_conv_pkg.sv
// Width/latency helpers and the round-and-saturate step for the USM convolution pipe.
// USM_CONV_ROUND_EN selects the rounded CH_WIDTH output format.
package usm_conv_pkg;

  function automatic bit round_en();
`ifdef USM_CONV_ROUND_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int unsigned tree_levels(input int unsigned cov_size);
    return $clog2(cov_size);
  endfunction

  // Pixel is zero-extended by one bit so the signed multiply never loses magnitude
  function automatic int unsigned prod_width(input int unsigned ch_width,
                                             input int unsigned weight_width);
    return ch_width + weight_width + 1;
  endfunction

  function automatic int unsigned sum_width(input int unsigned ch_width,
                                            input int unsigned weight_width,
                                            input int unsigned cov_size);
    return prod_width(ch_width, weight_width) + tree_levels(cov_size);
  endfunction

  function automatic int unsigned out_width(input int unsigned ch_width,
                                            input int unsigned sum_w);
    return round_en() ? ch_width : sum_w;
  endfunction

  function automatic int unsigned latency(input int unsigned cov_size);
    return 1 + tree_levels(cov_size) + (round_en() ? 1 : 0);
  endfunction

  // Add half an LSB, arithmetic shift, then clamp to the unsigned pixel range
  function automatic logic [63:0] round_sat(input logic signed [63:0] sum,
                                            input int unsigned frac_bits,
                                            input int unsigned ch_width);
    logic signed [63:0] t;
    logic signed [63:0] max_v;
    t = sum;
    if (frac_bits > 0) t = t + (64'sd1 <<< (frac_bits - 1));
    t = t >>> frac_bits;
    max_v = (64'sd1 <<< ch_width) - 64'sd1;
    if (t < 64'sd0)
      t = 64'sd0;
    else if (t > max_v)
      t = max_v;
    return t;
  endfunction

endpackage

// File: rtl/vector_conv_pipe_adder_tree.sv
// Registered signed N-input pairwise reduction; every level shares one stall enable.
// A zero-padded upper half lets an odd element ride through a level by adding zero.
module adder_tree_pipe #(
  parameter int unsigned N     = 3,
  parameter int unsigned IN_W  = 17,
  parameter int unsigned OUT_W = IN_W + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N*IN_W-1:0]       in_data,
  output logic signed [OUT_W-1:0] sum
);

  localparam int unsigned LEVELS = $clog2(N);

  logic signed [OUT_W-1:0] leaf_c [2*N];

  always_comb begin
    for (int i = 0; i < int'(2*N); i++) leaf_c[i] = '0;
    for (int i = 0; i < int'(N); i++)
      leaf_c[i] = OUT_W'($signed(in_data[i*IN_W +: IN_W]));
  end

  if (LEVELS == 0) begin : g_pass
    assign sum = leaf_c[0];
  end else begin : g_tree
    logic signed [OUT_W-1:0] node_q [LEVELS][2*N];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int l = 0; l < int'(LEVELS); l++)
          for (int i = 0; i < int'(2*N); i++) node_q[l][i] <= '0;
      end else if (en) begin
        for (int i = 0; i < int'(N); i++)
          node_q[0][i] <= leaf_c[2*i] + leaf_c[2*i+1];
        for (int i = int'(N); i < int'(2*N); i++) node_q[0][i] <= '0;
        for (int l = 1; l < int'(LEVELS); l++) begin
          for (int i = 0; i < int'(N); i++)
            node_q[l][i] <= node_q[l-1][2*i] + node_q[l-1][2*i+1];
          for (int i = int'(N); i < int'(2*N); i++) node_q[l][i] <= '0;
        end
      end
    end

    assign sum = node_q[LEVELS-1][0];
  end

endmodule

// File: rtl/vector_conv_pipe.sv
// Multi-channel pipelined 1-D convolution with signed runtime kernel and valid/ready stall.
// USM_CONV_ROUND_EN adds a registered round/shift/saturate stage with CH_WIDTH outputs.
module vector_conv_pipe
  import usm_conv_pkg::*;
#(
  parameter int unsigned LENGTH       = 10,
  parameter int unsigned COV_SIZE     = 3,
  parameter int unsigned CH_WIDTH     = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned FRAC_BITS    = 4,
  localparam int unsigned OUT_LEN = LENGTH - COV_SIZE + 1,
  localparam int unsigned TREE    = tree_levels(COV_SIZE),
  localparam int unsigned PROD_W  = prod_width(CH_WIDTH, WEIGHT_WIDTH),
  localparam int unsigned SUM_W   = sum_width(CH_WIDTH, WEIGHT_WIDTH, COV_SIZE),
  localparam int unsigned OUT_W   = out_width(CH_WIDTH, SUM_W)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 weight_we,
  input  logic [COV_SIZE*WEIGHT_WIDTH-1:0]     weight_in,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [CHANNELS*LENGTH*CH_WIDTH-1:0]  in_pixels,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [CHANNELS*OUT_LEN*OUT_W-1:0]    out_data
);

  localparam int unsigned N_DOT = CHANNELS * OUT_LEN;

  if (COV_SIZE == 0 || LENGTH < COV_SIZE || FRAC_BITS >= SUM_W) begin : g_bad_param
    $error("vector_conv_pipe: need 1 <= COV_SIZE <= LENGTH and FRAC_BITS < SUM_W");
  end

  logic                            stall_c;
  logic                            en_c;
  logic signed [WEIGHT_WIDTH-1:0]  kernel_q [COV_SIZE];
  logic [COV_SIZE*PROD_W-1:0]      prod_q   [N_DOT];
  logic [TREE:0]                   vld_q;
  logic signed [SUM_W-1:0]         dot_sum  [N_DOT];

  // One global stall freezes every stage, so data and valids never slip apart
  assign stall_c  = out_valid && !out_ready;
  assign en_c     = !stall_c;
  assign in_ready = !stall_c;

  // Kernel loads independently of the handshake; a beat taken on the load edge sees the old taps
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < int'(COV_SIZE); j++) kernel_q[j] <= '0;
    end else if (weight_we) begin
      for (int j = 0; j < int'(COV_SIZE); j++)
        kernel_q[j] <= weight_in[j*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  // Stage 0: every tap product of every window, plus the valid pipeline alongside the tree
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int n = 0; n < int'(N_DOT); n++) prod_q[n] <= '0;
    end else if (en_c) begin
      vld_q[0] <= in_valid;
      for (int l = 1; l <= int'(TREE); l++) vld_q[l] <= vld_q[l-1];
      for (int c = 0; c < int'(CHANNELS); c++)
        for (int k = 0; k < int'(OUT_LEN); k++)
          for (int j = 0; j < int'(COV_SIZE); j++)
            prod_q[c*OUT_LEN+k][j*PROD_W +: PROD_W] <=
              PROD_W'($signed({1'b0, in_pixels[(c*LENGTH+k+j)*CH_WIDTH +: CH_WIDTH]}))
              * PROD_W'(kernel_q[j]);
    end
  end

  for (genvar n = 0; n < N_DOT; n++) begin : g_dot
    adder_tree_pipe #(
      .N     (COV_SIZE),
      .IN_W  (PROD_W),
      .OUT_W (SUM_W)
    ) u_tree (
      .clk     (clk),
      .rst     (rst),
      .en      (en_c),
      .in_data (prod_q[n]),
      .sum     (dot_sum[n])
    );
  end

`ifdef USM_CONV_ROUND_EN
  logic [OUT_W-1:0] rnd_q [N_DOT];
  logic             rnd_vld_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_vld_q <= 1'b0;
      for (int n = 0; n < int'(N_DOT); n++) rnd_q[n] <= '0;
    end else if (en_c) begin
      rnd_vld_q <= vld_q[TREE];
      for (int n = 0; n < int'(N_DOT); n++)
        rnd_q[n] <= OUT_W'(round_sat(64'(dot_sum[n]), FRAC_BITS, CH_WIDTH));
    end
  end

  assign out_valid = rnd_vld_q;

  always_comb begin
    out_data = '0;
    for (int n = 0; n < int'(N_DOT); n++) out_data[n*OUT_W +: OUT_W] = rnd_q[n];
  end
`else
  assign out_valid = vld_q[TREE];

  always_comb begin
    out_data = '0;
    for (int n = 0; n < int'(N_DOT); n++) out_data[n*OUT_W +: OUT_W] = dot_sum[n];
  end
`endif

endmodule

// File: tb/tb_vector_conv_pipe.sv
// Scoreboard bench for vector_conv_pipe: directed beats push expected values, a monitor pops on output.
// Runs in either build; USM_CONV_ROUND_EN selects the rounded expectations.
module tb_vector_conv_pipe;

  localparam int unsigned LENGTH = 10;
  localparam int unsigned COV    = 3;
  localparam int unsigned CHW    = 8;
  localparam int unsigned WW     = 8;
  localparam int unsigned CH     = 3;
  localparam int unsigned N_DOT  = 24;
  localparam int unsigned PXW    = CH * LENGTH * CHW;
`ifdef USM_CONV_ROUND_EN
  localparam int unsigned OUT_W = 8;
  localparam int          LAT   = 4;
  localparam int          SCALE = 16;
`else
  localparam int unsigned OUT_W = 19;
  localparam int          LAT   = 3;
  localparam int          SCALE = 1;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   weight_we;
  logic [COV*WW-1:0]      weight_in;
  logic                   in_valid;
  logic                   in_ready;
  logic [PXW-1:0]         in_pixels;
  logic                   out_valid;
  logic                   out_ready;
  logic [N_DOT*OUT_W-1:0] out_data;

  vector_conv_pipe #(
    .LENGTH(LENGTH), .COV_SIZE(COV), .CH_WIDTH(CHW),
    .WEIGHT_WIDTH(WW), .CHANNELS(CH), .FRAC_BITS(4)
  ) dut (
    .clk(clk), .rst(rst), .weight_we(weight_we), .weight_in(weight_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixels(in_pixels),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int val;
    int acc;
    bit chk_lat;
    int id;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   beat_id = 0;

  function automatic logic [PXW-1:0] uniform_px(input int p);
    logic [PXW-1:0] v;
    for (int n = 0; n < int'(CH*LENGTH); n++) v[n*CHW +: CHW] = CHW'(p);
    return v;
  endfunction

  function automatic logic [PXW-1:0] ramp_px();
    logic [PXW-1:0] v;
    for (int c = 0; c < int'(CH); c++)
      for (int i = 0; i < int'(LENGTH); i++) v[(c*LENGTH+i)*CHW +: CHW] = CHW'(i);
    return v;
  endfunction

  function automatic logic [COV*WW-1:0] kern(input int w0, input int w1, input int w2);
    return {WW'(w2), WW'(w1), WW'(w0)};
  endfunction

  task automatic check(input string name, input longint got, input longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // All tasks start and end at posedge+1 so stimulus never races the negedge samplers
  task automatic load_kernel(input logic [COV*WW-1:0] w);
    weight_in = w;
    weight_we = 1'b1;
    @(posedge clk); #1;
    weight_we = 1'b0;
  endtask

  task automatic send(input logic [PXW-1:0] px, input int val, input bit push,
                      input bit chk_lat, input bit load_w, input logic [COV*WW-1:0] new_w);
    int   guard;
    exp_t e;
    in_pixels = px;
    in_valid  = 1'b1;
    guard     = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout beat%0d: in_ready stayed 0, want 1", beat_id);
    end else begin
      if (load_w) begin
        weight_in = new_w;
        weight_we = 1'b1;
      end
      if (push) begin
        e.val = val; e.acc = cyc + 1; e.chk_lat = chk_lat; e.id = beat_id;
        sb_q.push_back(e);
      end
      beat_id++;
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    weight_we = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() != 0 && g < 100) begin
      @(posedge clk);
      g++;
    end
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, want 0", sb_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: every transferred output must match the oldest pending expectation
  exp_t             mon_e;
  int               mon_bad;
  int               mon_lat;
  logic [OUT_W-1:0] mon_want;
  logic [OUT_W-1:0] mon_got;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: out_valid=1 with nothing pending, want no output");
      end else begin
        mon_e    = sb_q.pop_front();
        mon_want = OUT_W'(mon_e.val);
        mon_bad  = -1;
        mon_got  = '0;
        for (int n = 0; n < int'(N_DOT); n++)
          if (mon_bad < 0 && out_data[n*OUT_W +: OUT_W] != mon_want) begin
            mon_bad = n;
            mon_got = out_data[n*OUT_W +: OUT_W];
          end
        if (mon_bad >= 0) begin
          n_fail++;
          $display("FAIL beat%0d_data field %0d: got 0x%0h, want 0x%0h",
                   mon_e.id, mon_bad, mon_got, mon_want);
        end
        if (mon_e.chk_lat) begin
          n_tests++;
          mon_lat = cyc - mon_e.acc + 1;
          if (mon_lat != LAT) begin
            n_fail++;
            $display("FAIL beat%0d_latency: got %0d cycles, want %0d", mon_e.id, mon_lat, LAT);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [N_DOT*OUT_W-1:0] held;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pixels = '0; out_ready = 1'b1;
    weight_we = 1'b0; weight_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data_zero", out_data == '0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    // Smoothing kernel on a flat image, with latency measured on this beat
    load_kernel(kern(1*SCALE, 2*SCALE, 1*SCALE));
    send(uniform_px(10), 40, 1, 1, 0, '0);
    drain();

`ifndef USM_CONV_ROUND_EN
    // Signed taps: gradient of a ramp, then the most negative product sign-extended
    load_kernel(kern(-1, 0, 1));
    send(ramp_px(), 2, 1, 0, 0, '0);
    load_kernel(kern(-128, 0, 0));
    send(uniform_px(255), -32640, 1, 0, 0, '0);
    drain();
`endif

    // Back-to-back stream with a 4-cycle downstream stall in the middle
    load_kernel(kern(1*SCALE, 2*SCALE, 1*SCALE));
    fork
      begin
        for (int p = 1; p <= 6; p++) send(uniform_px(p), 4*p, 1, 0, 0, '0);
      end
      begin
        int g = 0;
        @(negedge clk);
        while (!out_valid && g < 50) begin
          g++;
          @(negedge clk);
        end
        check("stall_first_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_out_valid", out_valid, 1);
          if (s == 0) held = out_data;
          else check("stall_data_held", out_data == held, 1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_after_stall", in_ready, 1);
        @(posedge clk); #1;
      end
    join
    drain();

    // Kernel swap in the same cycle as beat 2: beats 1-2 old taps, beats 3-4 new taps
    load_kernel(kern(1*SCALE, 1*SCALE, 1*SCALE));
    send(uniform_px(1), 3, 1, 0, 0, '0);
    send(uniform_px(1), 3, 1, 0, 1, kern(2*SCALE, 2*SCALE, 2*SCALE));
    send(uniform_px(1), 6, 1, 0, 0, '0);
    send(uniform_px(1), 6, 1, 0, 0, '0);
    drain();

    // Reset with two beats in flight: both are discarded and the kernel clears
    send(uniform_px(255), 0, 0, 0, 0, '0);
    send(uniform_px(255), 0, 0, 0, 0, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_out_data_zero", out_data == '0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_midreset", in_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    send(uniform_px(255), 0, 1, 0, 0, '0);
    drain();

`ifdef USM_CONV_ROUND_EN
    // Rounding: exact fit, positive saturation, negative clamp
    load_kernel(kern(4, 8, 4));
    send(uniform_px(255), 255, 1, 0, 0, '0);
    load_kernel(kern(16, 16, 16));
    send(uniform_px(255), 255, 1, 0, 0, '0);
    load_kernel(kern(-16, 0, 0));
    send(uniform_px(255), 0, 1, 0, 0, '0);
    drain();
`endif

    check("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
